// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two in-order FIFOs (ALU, LSU) drained round-robin onto
// the single register-file write port, with pending-write flags for issue hazards.
module wb_port_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          alu_valid_i,
  input  logic [AW-1:0] alu_rd_i,
  input  logic [DW-1:0] alu_dat_i,
  output logic          alu_ready_o,
  input  logic          lsu_valid_i,
  input  logic [AW-1:0] lsu_rd_i,
  input  logic [DW-1:0] lsu_dat_i,
  output logic          lsu_ready_o,
  output logic          wr_en_o,
  output logic [AW-1:0] reg_des_o,
  output logic [DW-1:0] reg_des_dat_o,
  input  logic [AW-1:0] hz_rs1_i,
  input  logic [AW-1:0] hz_rs2_i,
  output logic          hz_rs1_pend_o,
  output logic          hz_rs2_pend_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  // Requester index 0 is the ALU, 1 is the LSU.
  logic [AW-1:0] rd_q   [2][DEPTH];
  logic [DW-1:0] dat_q  [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic          last_lsu_q, last_lsu_d;

  logic          in_valid [2];
  logic [AW-1:0] in_rd    [2];
  logic [DW-1:0] in_dat   [2];
  logic          ready    [2];
  logic          push     [2];
  logic          pop      [2];
  logic          not_empty[2];
  logic          gnt_lsu, gnt_alu;
  logic          rs1_hit, rs2_hit;
  logic [PW-1:0] off;

  assign in_valid[0] = alu_valid_i;
  assign in_valid[1] = lsu_valid_i;
  assign in_rd[0]    = alu_rd_i;
  assign in_rd[1]    = lsu_rd_i;
  assign in_dat[0]   = alu_dat_i;
  assign in_dat[1]   = lsu_dat_i;

  // Handshake, x0 filtering and round-robin grant, all from registered state.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      ready[r]     = (cnt_q[r] != CW'(DEPTH));
      not_empty[r] = (cnt_q[r] != '0);
      // rd=0 is accepted but dropped: writes to x0 have no effect.
      push[r]      = in_valid[r] && ready[r] && (in_rd[r] != '0);
    end
    gnt_lsu = not_empty[1] && (!not_empty[0] || !last_lsu_q);
    gnt_alu = not_empty[0] && !gnt_lsu;
    pop[0]  = gnt_alu;
    pop[1]  = gnt_lsu;
  end

  // Next-state for pointers, counts and the round-robin pointer.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      wptr_d[r] = push[r] ? wptr_q[r] + PW'(1) : wptr_q[r];
      rptr_d[r] = pop[r]  ? rptr_q[r] + PW'(1) : rptr_q[r];
      cnt_d[r]  = cnt_q[r];
      if (push[r] && !pop[r]) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (!push[r] && pop[r]) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
    last_lsu_d = last_lsu_q;
    if (gnt_alu || gnt_lsu) begin
      last_lsu_d = gnt_lsu;
    end
  end

  // State register; reset leaves last grant at LSU so the ALU wins first.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 2; r++) begin
        wptr_q[r] <= '0;
        rptr_q[r] <= '0;
        cnt_q[r]  <= '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
          rd_q[r][i]  <= '0;
          dat_q[r][i] <= '0;
        end
      end
      last_lsu_q <= 1'b1;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) begin
          rd_q[r][wptr_q[r]]  <= in_rd[r];
          dat_q[r][wptr_q[r]] <= in_dat[r];
        end
        wptr_q[r] <= wptr_d[r];
        rptr_q[r] <= rptr_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      last_lsu_q <= last_lsu_d;
    end
  end

  // Write port driven by the granted head; zero when idle.
  always_comb begin
    alu_ready_o   = ready[0];
    lsu_ready_o   = ready[1];
    wr_en_o       = not_empty[0] || not_empty[1];
    reg_des_o     = '0;
    reg_des_dat_o = '0;
    if (gnt_alu) begin
      reg_des_o     = rd_q[0][rptr_q[0]];
      reg_des_dat_o = dat_q[0][rptr_q[0]];
    end else if (gnt_lsu) begin
      reg_des_o     = rd_q[1][rptr_q[1]];
      reg_des_dat_o = dat_q[1][rptr_q[1]];
    end
  end

  // Pending-write search over occupied slots of both FIFOs, head included.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    off     = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        off = PW'(i) - rptr_q[r];
        if ({1'b0, off} < cnt_q[r]) begin
          if (rd_q[r][i] == hz_rs1_i) rs1_hit = 1'b1;
          if (rd_q[r][i] == hz_rs2_i) rs2_hit = 1'b1;
        end
      end
    end
    hz_rs1_pend_o = rs1_hit && (hz_rs1_i != '0);
    hz_rs2_pend_o = rs2_hit && (hz_rs2_i != '0);
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          alu_valid_i = 1'b0;
  logic [AW-1:0] alu_rd_i = '0;
  logic [DW-1:0] alu_dat_i = '0;
  logic          alu_ready_o;
  logic          lsu_valid_i = 1'b0;
  logic [AW-1:0] lsu_rd_i = '0;
  logic [DW-1:0] lsu_dat_i = '0;
  logic          lsu_ready_o;
  logic          wr_en_o;
  logic [AW-1:0] reg_des_o;
  logic [DW-1:0] reg_des_dat_o;
  logic [AW-1:0] hz_rs1_i = '0;
  logic [AW-1:0] hz_rs2_i = '0;
  logic          hz_rs1_pend_o;
  logic          hz_rs2_pend_o;

  wb_port_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_dat_i     (alu_dat_i),
    .alu_ready_o   (alu_ready_o),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_dat_i     (lsu_dat_i),
    .lsu_ready_o   (lsu_ready_o),
    .wr_en_o       (wr_en_o),
    .reg_des_o     (reg_des_o),
    .reg_des_dat_o (reg_des_dat_o),
    .hz_rs1_i      (hz_rs1_i),
    .hz_rs2_i      (hz_rs2_i),
    .hz_rs1_pend_o (hz_rs1_pend_o),
    .hz_rs2_pend_o (hz_rs2_pend_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one queue of {rd, dat} per requester plus who was granted last.
  logic [AW+DW-1:0] aq[$];
  logic [AW+DW-1:0] lq[$];
  bit               last_lsu = 1'b1;

  // Values observed from the DUT in the most recent cycle, for literal checks.
  logic          obs_wr, obs_ardy, obs_lrdy, obs_p1, obs_p2;
  logic [AW-1:0] obs_des;
  logic [DW-1:0] obs_dat;
  bit            last_acc_lsu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pend(input logic [AW-1:0] rs);
    if (rs == '0) return 1'b0;
    foreach (aq[i]) if (aq[i][AW+DW-1:DW] == rs) return 1'b1;
    foreach (lq[i]) if (lq[i][AW+DW-1:DW] == rs) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, compare every output with the model, then advance the model.
  task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit            e_ar, e_lr, e_wr, g_alu;
    logic [AW-1:0] e_des;
    logic [DW-1:0] e_dat;
    @(negedge clk);
    alu_valid_i = av;  alu_rd_i = ard;  alu_dat_i = adat;
    lsu_valid_i = lv;  lsu_rd_i = lrd;  lsu_dat_i = ldat;
    hz_rs1_i = rs1;    hz_rs2_i = rs2;
    #1;
    e_ar  = (aq.size() != DEPTH);
    e_lr  = (lq.size() != DEPTH);
    e_wr  = (aq.size() != 0) || (lq.size() != 0);
    g_alu = (aq.size() != 0) && ((lq.size() == 0) || last_lsu);
    e_des = '0;
    e_dat = '0;
    if (e_wr) begin
      if (g_alu) {e_des, e_dat} = aq[0];
      else       {e_des, e_dat} = lq[0];
    end
    obs_wr = wr_en_o;  obs_des = reg_des_o;  obs_dat = reg_des_dat_o;
    obs_ardy = alu_ready_o;  obs_lrdy = lsu_ready_o;
    obs_p1 = hz_rs1_pend_o;  obs_p2 = hz_rs2_pend_o;
    chk("wr_en", obs_wr, e_wr);
    chk("reg_des", obs_des, e_des);
    chk("reg_des_dat", obs_dat, e_dat);
    chk("alu_ready", obs_ardy, e_ar);
    chk("lsu_ready", obs_lrdy, e_lr);
    chk("rs1_pend", obs_p1, model_pend(rs1));
    chk("rs2_pend", obs_p2, model_pend(rs2));
    last_acc_lsu = lv && e_lr;
    @(posedge clk);
    if (e_wr) begin
      if (g_alu) void'(aq.pop_front());
      else       void'(lq.pop_front());
      last_lsu = !g_alu;
    end
    if (av && e_ar && ard != '0) aq.push_back({ard, adat});
    if (lv && e_lr && lrd != '0) lq.push_back({lrd, ldat});
  endtask

  task automatic idle(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, rs1, rs2);
  endtask

  // Reset asserted in the middle of a low clock phase; outputs must clear at once.
  task automatic do_reset(input logic [AW-1:0] rs1);
    @(negedge clk);
    alu_valid_i = 1'b0;  lsu_valid_i = 1'b0;
    hz_rs1_i = rs1;      hz_rs2_i = '0;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_wr_en", wr_en_o, 1'b0);
    chk("rst_alu_ready", alu_ready_o, 1'b1);
    chk("rst_lsu_ready", lsu_ready_o, 1'b1);
    chk("rst_rs1_pend", hz_rs1_pend_o, 1'b0);
    aq.delete();
    lq.delete();
    last_lsu = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] lsu_seen[$];
    int            li;
    bit            saw_nr;
    logic [AW-1:0] rs;

    // Power-on reset state.
    #3;
    chk("por_wr_en", wr_en_o, 1'b0);
    chk("por_reg_des", reg_des_o, '0);
    chk("por_reg_dat", reg_des_dat_o, '0);
    chk("por_alu_ready", alu_ready_o, 1'b1);
    chk("por_lsu_ready", lsu_ready_o, 1'b1);
    @(negedge clk);
    rst_i = 1'b0;

    // Single ALU write: visible the cycle after the handshake, gone the cycle after that.
    cycle(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, '0, '0);
    idle('0, '0);
    chk("t1_wr_en", obs_wr, 1'b1);
    chk("t1_des", obs_des, 5'd3);
    chk("t1_dat", obs_dat, 32'h11);
    idle('0, '0);
    chk("t1_idle", obs_wr, 1'b0);

    // Simultaneous pushes after reset: ALU wins first, then LSU.
    do_reset('0);
    cycle(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, '0, '0);
    idle('0, '0);
    chk("t2_first_des", obs_des, 5'd5);
    chk("t2_first_dat", obs_dat, 32'hA);
    idle('0, '0);
    chk("t2_second_des", obs_des, 5'd6);
    chk("t2_second_dat", obs_dat, 32'hB);
    cycle(1'b1, 5'd5, 32'h15, 1'b1, 5'd6, 32'h16, '0, '0);
    idle('0, '0);
    idle('0, '0);
    idle('0, '0);

    // LSU streams rd 1..4 against a continuous ALU stream.
    do_reset('0);
    li = 1;
    saw_nr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, AW'(10 + (k % 4)), $urandom, li <= 4, AW'(li), $urandom, '0, '0);
      if (obs_wr && obs_des >= 1 && obs_des <= 4) lsu_seen.push_back(obs_des);
      if (!obs_lrdy) saw_nr = 1'b1;
      if (last_acc_lsu && li <= 4) li++;
    end
    for (int k = 0; k < 6; k++) begin
      idle('0, '0);
      if (obs_wr && obs_des >= 1 && obs_des <= 4) lsu_seen.push_back(obs_des);
    end
    chk("t3_lsu_backpressure", saw_nr, 1'b1);
    chk("t3_lsu_count", lsu_seen.size(), 4);
    for (int i = 0; i < 4 && i < lsu_seen.size(); i++) chk("t3_lsu_order", lsu_seen[i], i + 1);

    // Write to x0 is accepted and dropped.
    cycle(1'b1, '0, 32'hFFFF, 1'b0, '0, '0, '0, '0);
    idle('0, '0);
    chk("t4_wr_en", obs_wr, 1'b0);
    chk("t4_alu_ready", obs_ardy, 1'b1);
    idle('0, '0);
    chk("t4_wr_en_later", obs_wr, 1'b0);

    // LSU rd=7 waits behind the ALU; its hazard flag holds until it is written.
    do_reset('0);
    cycle(1'b1, 5'd8, 32'h80, 1'b1, 5'd7, 32'h70, '0, '0);
    cycle(1'b1, 5'd9, 32'h90, 1'b0, '0, '0, 5'd7, '0);
    chk("t5_pend1_wait", obs_p1, 1'b1);
    chk("t5_pend2_zero", obs_p2, 1'b0);
    chk("t5_alu_first", obs_des, 5'd8);
    idle(5'd7, '0);
    chk("t5_lsu_head_des", obs_des, 5'd7);
    chk("t5_pend1_head", obs_p1, 1'b1);
    idle(5'd7, '0);
    chk("t5_pend1_clear", obs_p1, 1'b0);
    chk("t5_alu_last", obs_des, 5'd9);
    idle('0, '0);

    // Random traffic, including x0 writes and hazard probes.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // Fill both FIFOs, then reset mid-cycle; nothing stale may come out afterwards.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, AW'(11 + k), $urandom, 1'b1, AW'(21 + k), $urandom, '0, '0);
    end
    rs = (aq.size() != 0) ? aq[0][AW+DW-1:DW] : 5'd11;
    do_reset(rs);
    for (int k = 0; k < 3; k++) begin
      idle(rs, '0);
      chk("t6_no_stale", obs_wr, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
